dtw_ref_arbiter: RTL and testbench

//   Round-robin arbiter that shares the single read port of the reference memory among
//   NUM_CORES DTW cores. Issues at most one read per cycle and tracks in-flight reads

---
 rtl/dtw_ref_arbiter.sv | 147 ++++++++++++++
 tb/tb_dtw_ref_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtw_ref_arbiter.sv
// Round-robin arbiter sharing the reference-memory read port among the DTW cores.
// Read data is steered back to the issuing core through a RD_LATENCY-deep tag pipeline.
module dtw_ref_arbiter #(
    parameter int NUM_CORES        = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int REFMEM_PTR_WIDTH = 20,
    parameter int RD_LATENCY       = 1,
    parameter int IDX_WIDTH        = 2
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic                                  ref_load_busy_in,
    output logic                                  arb_idle_out,
    input  logic [NUM_CORES-1:0]                  req_in,
    input  logic [NUM_CORES*REFMEM_PTR_WIDTH-1:0] addr_in,
    output logic [NUM_CORES-1:0]                  gnt_out,
    output logic [NUM_CORES-1:0]                  rvalid_out,
    output logic [DATA_WIDTH-1:0]                 rdata_out,
    output logic                                  mem_rden_out,
    output logic [REFMEM_PTR_WIDTH-1:0]           mem_addr_out,
    input  logic [DATA_WIDTH-1:0]                 mem_data_in,
    output logic [1:0]                            dbg_state,
    output logic [IDX_WIDTH-1:0]                  dbg_last_gnt
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [IDX_WIDTH-1:0]   last_gnt_r;
    logic [IDX_WIDTH-1:0]   winner_s;
    logic [IDX_WIDTH-1:0]   cand_s;
    logic                   found_s;
    logic                   gnt_en_s;
    logic                   gnt_any_s;
    logic                   ret_s;
    logic [CNT_W-1:0]       inflight_r;
    logic [CNT_W-1:0]       inflight_nxt_s;
    logic                   tag_vld_r [RD_LATENCY];
    logic [IDX_WIDTH-1:0]   tag_idx_r [RD_LATENCY];

    // Round-robin search starting one past the last granted core.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        cand_s   = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand_s = IDX_WIDTH'((int'(last_gnt_r) + k) % NUM_CORES);
            if (!found_s && req_in[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant, memory strobe and read-data return; reset suppresses both directions at once.
    always_comb begin
        gnt_en_s     = !rst_in && !ref_load_busy_in && (state_r != ST_DRAIN);
        gnt_any_s    = gnt_en_s && found_s;
        gnt_out      = gnt_any_s ? (NUM_CORES'(1) << winner_s) : '0;
        mem_rden_out = gnt_any_s;
        mem_addr_out = gnt_any_s ? addr_in[winner_s*REFMEM_PTR_WIDTH +: REFMEM_PTR_WIDTH] : '0;
        ret_s        = tag_vld_r[RD_LATENCY-1] && !rst_in;
        rvalid_out   = ret_s ? (NUM_CORES'(1) << tag_idx_r[RD_LATENCY-1]) : '0;
        rdata_out    = ret_s ? mem_data_in : '0;
    end

    // In-flight bookkeeping: a grant and a return in the same cycle cancel out.
    always_comb begin
        inflight_nxt_s = inflight_r;
        case ({gnt_any_s, tag_vld_r[RD_LATENCY-1]})
            2'b10:   inflight_nxt_s = inflight_r + CNT_W'(1);
            2'b01:   inflight_nxt_s = inflight_r - CNT_W'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Next-state logic; DRAIN is entered from the current count so a read returning
    // in the busy cycle still passes through DRAIN before the loader is released.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ref_load_busy_in && (inflight_r != CNT_W'(0))) begin
                    state_nxt_s = ST_DRAIN;
                end else if (!gnt_any_s && (inflight_nxt_s == CNT_W'(0))) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                if (inflight_r == CNT_W'(0)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, priority pointer, in-flight count and tag pipeline registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= IDX_WIDTH'(NUM_CORES - 1);
            inflight_r <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_vld_r[i] <= 1'b0;
                tag_idx_r[i] <= '0;
            end
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= inflight_nxt_s;
            if (gnt_any_s) begin
                last_gnt_r <= winner_s;
            end
            tag_vld_r[0] <= gnt_any_s;
            tag_idx_r[0] <= winner_s;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_idx_r[i] <= tag_idx_r[i-1];
            end
        end
    end

    assign arb_idle_out = (state_r == ST_IDLE);
    assign dbg_state    = state_r;
    assign dbg_last_gnt = last_gnt_r;

endmodule

// File: tb/tb_dtw_ref_arbiter.sv
// Directed bench for dtw_ref_arbiter: one instance at RD_LATENCY=1, one at RD_LATENCY=3.
module tb_dtw_ref_arbiter;

    localparam int NC = 4;
    localparam int DW = 16;
    localparam int AW = 20;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              busy;
    logic [NC-1:0]     req;
    logic [NC*AW-1:0]  addr;
    logic              idle;
    logic [NC-1:0]     gnt;
    logic [NC-1:0]     rvalid;
    logic [DW-1:0]     rdata;
    logic              rden;
    logic [AW-1:0]     maddr;
    logic [DW-1:0]     mdata;
    logic [1:0]        st;
    logic [1:0]        lastg;

    logic [NC-1:0]     req3;
    logic [NC*AW-1:0]  addr3;
    logic              idle3;
    logic [NC-1:0]     gnt3;
    logic [NC-1:0]     rvalid3;
    logic [DW-1:0]     rdata3;
    logic              rden3;
    logic [AW-1:0]     maddr3;
    logic [DW-1:0]     m3_a, m3_b, m3_c;
    logic [1:0]        st3;
    logic [1:0]        lastg3;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [NC-1:0] one4 = 4'b0001;
    logic [AW-1:0] t5_addr [4];

    always #5 clk_in = ~clk_in;

    dtw_ref_arbiter #(.NUM_CORES(NC), .DATA_WIDTH(DW), .REFMEM_PTR_WIDTH(AW),
                      .RD_LATENCY(1), .IDX_WIDTH(2)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .ref_load_busy_in(busy), .arb_idle_out(idle),
        .req_in(req), .addr_in(addr), .gnt_out(gnt), .rvalid_out(rvalid), .rdata_out(rdata),
        .mem_rden_out(rden), .mem_addr_out(maddr), .mem_data_in(mdata),
        .dbg_state(st), .dbg_last_gnt(lastg)
    );

    dtw_ref_arbiter #(.NUM_CORES(NC), .DATA_WIDTH(DW), .REFMEM_PTR_WIDTH(AW),
                      .RD_LATENCY(3), .IDX_WIDTH(2)) u_dut3 (
        .clk_in(clk_in), .rst_in(rst_in), .ref_load_busy_in(1'b0), .arb_idle_out(idle3),
        .req_in(req3), .addr_in(addr3), .gnt_out(gnt3), .rvalid_out(rvalid3), .rdata_out(rdata3),
        .mem_rden_out(rden3), .mem_addr_out(maddr3), .mem_data_in(m3_c),
        .dbg_state(st3), .dbg_last_gnt(lastg3)
    );

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    // Reference memory models: 1-cycle and 3-cycle read latency.
    always @(posedge clk_in) begin
        mdata <= memf(maddr);
        m3_a  <= memf(maddr3);
        m3_b  <= m3_a;
        m3_c  <= m3_b;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_pt();
        @(negedge clk_in);
    endtask

    initial begin
        rst_in = 1'b1; busy = 1'b0; req = '0; addr = '0; req3 = '0; addr3 = '0;
        t5_addr[0] = 20'h00040; t5_addr[1] = 20'h00042;
        t5_addr[2] = 20'h00044; t5_addr[3] = 20'h00046;
        cyc(); cyc();
        req = 4'b1111;
        chk_pt();
        check_vec("rst_gnt",    32'(gnt),    32'h0);
        check_vec("rst_rden",   32'(rden),   32'h0);
        check_vec("rst_rvalid", 32'(rvalid), 32'h0);
        check_vec("rst_rdata",  32'(rdata),  32'h0);
        check_vec("rst_idle",   32'(idle),   32'h1);
        check_vec("rst_state",  32'(st),     32'h0);
        check_vec("rst_lastg",  32'(lastg),  32'h3);
        check_vec("rst_idle3",  32'(idle3),  32'h1);

        // 1: core 2 alone
        cyc(); rst_in = 1'b0; req = 4'b0100; addr[2*AW +: AW] = 20'h00010;
        chk_pt();
        check_vec("t1_gnt",   32'(gnt),   32'h4);
        check_vec("t1_addr",  32'(maddr), 32'h10);
        check_vec("t1_rden",  32'(rden),  32'h1);
        cyc(); req = '0;
        chk_pt();
        check_vec("t1_rvalid", 32'(rvalid), 32'h4);
        check_vec("t1_rdata",  32'(rdata),  32'h10EF);
        check_vec("t1_gnt0",   32'(gnt),    32'h0);
        check_vec("t1_state",  32'(st),     32'h1);
        check_vec("t1_lastg",  32'(lastg),  32'h2);
        cyc();
        chk_pt();
        check_vec("t1_idle",   32'(idle),   32'h1);

        // 2: all cores requesting, fresh priority
        cyc(); rst_in = 1'b1;
        cyc(); rst_in = 1'b0; req = 4'b1111;
        for (int c = 0; c < NC; c++) addr[c*AW +: AW] = 20'h00100 + AW'(c);
        for (int k = 0; k < 8; k++) begin
            chk_pt();
            check_vec("t2_gnt",  32'(gnt),   32'(one4 << (k % 4)));
            check_vec("t2_addr", 32'(maddr), 32'h100 + 32'(k % 4));
            if (k > 0) begin
                check_vec("t2_rvalid", 32'(rvalid), 32'(one4 << ((k - 1) % 4)));
                check_vec("t2_rdata",  32'(rdata),  32'(memf(20'h00100 + AW'((k - 1) % 4))));
            end
            cyc();
        end
        req = '0;
        chk_pt();
        check_vec("t2_rvalid_last", 32'(rvalid), 32'h8);
        check_vec("t2_rdata_last",  32'(rdata),  32'h03FC);
        cyc();

        // 3: core 1 streams addresses 0..5
        for (int k = 0; k < 7; k++) begin
            req = (k < 6) ? 4'b0010 : 4'b0000;
            addr[1*AW +: AW] = AW'(k);
            chk_pt();
            if (k < 6) check_vec("t3_gnt", 32'(gnt), 32'h2);
            if (k > 0) begin
                check_vec("t3_rvalid", 32'(rvalid), 32'h2);
                check_vec("t3_rdata",  32'(rdata),  32'(memf(AW'(k - 1))));
            end
            cyc();
        end
        chk_pt();
        check_vec("t3_idle", 32'(idle), 32'h1);

        // 4: loader takes over while core 0 read is in flight
        cyc(); req = 4'b0001; addr[0 +: AW] = 20'h00020;
        chk_pt();
        check_vec("t4_gnt0", 32'(gnt), 32'h1);
        cyc(); req = 4'b1000; addr[3*AW +: AW] = 20'h00033; busy = 1'b1;
        chk_pt();
        check_vec("t4_blk",    32'(gnt),    32'h0);
        check_vec("t4_rvalid", 32'(rvalid), 32'h1);
        check_vec("t4_rdata",  32'(rdata),  32'h20DF);
        check_vec("t4_active", 32'(st),     32'h1);
        cyc();
        chk_pt();
        check_vec("t4_drain",  32'(st),     32'h2);
        check_vec("t4_nidle",  32'(idle),   32'h0);
        check_vec("t4_blk2",   32'(gnt),    32'h0);
        cyc();
        chk_pt();
        check_vec("t4_idle",   32'(idle),   32'h1);
        check_vec("t4_blk3",   32'(gnt),    32'h0);
        cyc(); busy = 1'b0;
        chk_pt();
        check_vec("t4_gnt3",   32'(gnt),    32'h8);
        check_vec("t4_addr3",  32'(maddr),  32'h33);
        cyc(); req = '0;
        chk_pt();
        check_vec("t4_rvalid3", 32'(rvalid), 32'h8);
        cyc(); cyc();

        // 5: latency 3, cores 0 and 2 alternating
        for (int k = 0; k < 8; k++) begin
            req3 = (k < 4) ? 4'b0101 : 4'b0000;
            addr3[0 +: AW]    = (k < 2) ? 20'h00040 : 20'h00044;
            addr3[2*AW +: AW] = (k < 2) ? 20'h00042 : 20'h00046;
            chk_pt();
            if (k < 4) check_vec("t5_gnt", 32'(gnt3), (k % 2 == 0) ? 32'h1 : 32'h4);
            if (k >= 3 && k <= 6) begin
                check_vec("t5_rvalid", 32'(rvalid3), ((k - 3) % 2 == 0) ? 32'h1 : 32'h4);
                check_vec("t5_rdata",  32'(rdata3),  32'(memf(t5_addr[k - 3])));
            end else begin
                check_vec("t5_norv", 32'(rvalid3), 32'h0);
            end
            if (k == 7) check_vec("t5_idle", 32'(idle3), 32'h1);
            cyc();
        end

        // 6: reset right after a grant to core 3
        req = 4'b1000; addr[3*AW +: AW] = 20'h00055;
        chk_pt();
        check_vec("t6_gnt3", 32'(gnt), 32'h8);
        cyc(); req = '0; rst_in = 1'b1;
        chk_pt();
        check_vec("t6_norv_rst", 32'(rvalid), 32'h0);
        check_vec("t6_rdata0",   32'(rdata),  32'h0);
        cyc(); rst_in = 1'b0;
        chk_pt();
        check_vec("t6_norv",  32'(rvalid), 32'h0);
        check_vec("t6_idle",  32'(idle),   32'h1);
        check_vec("t6_lastg", 32'(lastg),  32'h3);
        cyc(); req = 4'b1111;
        chk_pt();
        check_vec("t6_gnt0", 32'(gnt), 32'h1);
        cyc(); req = '0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
